mem_stage_ws: RTL

MEM_STAGE_WS -- requirements
Module: mem_stage_ws

---
 rtl/mem_stage_ws.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_ws.sv
// mem_stage_ws: pipeline memory stage with a word-addressed data array and a
// fixed number of wait states per access. Upstream is held via the
// combinational stall output while an access is in progress; the output
// register inserts bubbles (wb_en/mem_r_en cleared) on stalled edges.
// Optional build macro: MEM_RANGE_CHECK_EN enables out-of-range detection
// (addr_fault, write suppression, zero read data). Without it the word index
// wraps modulo DEPTH and addr_fault stays 0.
module mem_stage_ws #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_en_in,
  input  logic              mem_r_en_in,
  input  logic              mem_w_en_in,
  input  logic [4:0]        dest_in,
  input  logic [31:0]       alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  output logic              wb_en_out,
  output logic              mem_r_en_out,
  output logic [4:0]        dest_out,
  output logic [31:0]       alu_result_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              stall,
  output logic              addr_fault
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [31:0] BASE  = 32'(BASE_ADDR);
  localparam logic [32:0] SPAN  = 33'(DEPTH * BYTES);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               stall_c;
  logic               complete;
  logic               access;
  logic               in_range;
  logic               fault;
  logic               mem_we;
  logic [31:0]        offset;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  rdata;
  logic               unused_offset;

  logic [DATA_W-1:0]  mem_q [DEPTH] = '{default: '0};

  logic               wb_en_q;
  logic               mem_r_en_q;
  logic [4:0]         dest_q;
  logic [31:0]        alu_result_q;
  logic [DATA_W-1:0]  mem_data_q;
  logic               addr_fault_q;

  // Address decode: byte offset from the base, then word index.
  always_comb begin
    access = mem_r_en_in | mem_w_en_in;
    offset = alu_result_in - BASE;
    idx    = offset[OFF_W +: IDX_W];
`ifdef MEM_RANGE_CHECK_EN
    // Addresses below the base wrap to huge offsets, so one compare covers both bounds.
    in_range = ({1'b0, offset} < SPAN);
`else
    in_range = 1'b1;
`endif
    fault = access & ~in_range;
    rdata = in_range ? mem_q[idx] : '0;
  end

  assign unused_offset = ^offset;

  // Wait-state sequencing: next state, counter, stall and completion strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (WAIT_STATES == 0) begin
            complete = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = S_WAIT;
            cnt_d   = WS - 4'd1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset acts immediately on the combinational outputs too, so an access
    // interrupted by reset can never reach its write edge.
    if (rst) begin
      stall_c  = 1'b0;
      complete = 1'b0;
    end
  end

  assign stall  = stall_c;
  assign mem_we = complete & mem_w_en_in & in_range;

  // FSM state and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data array: single write on the completion edge; not touched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx] <= store_data_in;
    end
  end

  // Output register: load on free edges, bubble and hold on stalled edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      dest_q       <= '0;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      addr_fault_q <= 1'b0;
    end else if (stall_c) begin
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
    end else begin
      wb_en_q      <= wb_en_in;
      mem_r_en_q   <= mem_r_en_in;
      dest_q       <= dest_in;
      alu_result_q <= alu_result_in;
      mem_data_q   <= rdata;
      addr_fault_q <= fault;
    end
  end

  assign wb_en_out      = wb_en_q;
  assign mem_r_en_out   = mem_r_en_q;
  assign dest_out       = dest_q;
  assign alu_result_out = alu_result_q;
  assign mem_data_out   = mem_data_q;
  assign addr_fault     = addr_fault_q;

endmodule
